request_dispatcher: RTL and testbench

Parametrised, registered request dispatcher between the RR stage and the N downstream request queues (send, receive, and future channels). It decodes funct3 through a per-parameter routing map and steers each request into a one-entry output register per target. Illegal funct3 values no longer stall the RR stage; they are routed to a dedicated error-response port and counted. Accepted requests appear at the target one cycle later.

---
 rtl/request_dispatcher_if.sv | 40 ++++
 rtl/request_dispatcher.sv | 106 ++++++++++
 tb/tb_request_dispatcher.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/request_dispatcher_if.sv
// Request dispatcher bus: RR-side request handshake, per-target output slots and error response port.
// slave is the dispatcher's view; master is the driver/consumer side.
interface request_dispatcher_if #(
    parameter int NUM_TARGETS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int PT_WIDTH    = 8,
    parameter int CNT_WIDTH   = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [2:0]                      in_funct3;
    logic [DATA_WIDTH-1:0]           in_rs1;
    logic [DATA_WIDTH-1:0]           in_rs2;
    logic [PT_WIDTH-1:0]             in_passthrough;

    logic [NUM_TARGETS-1:0]          out_valid;
    logic [NUM_TARGETS-1:0]          out_ready;
    logic [3*NUM_TARGETS-1:0]        out_funct3;
    logic [DATA_WIDTH*NUM_TARGETS-1:0] out_rs1;
    logic [DATA_WIDTH*NUM_TARGETS-1:0] out_rs2;
    logic [PT_WIDTH*NUM_TARGETS-1:0] out_passthrough;

    logic                            err_valid;
    logic                            err_ready;
    logic [2:0]                      err_funct3;
    logic [PT_WIDTH-1:0]             err_passthrough;
    logic [CNT_WIDTH-1:0]            illegal_count;

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_passthrough, out_ready, err_ready,
        output in_ready, out_valid, out_funct3, out_rs1, out_rs2, out_passthrough,
               err_valid, err_funct3, err_passthrough, illegal_count
    );

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_passthrough, out_ready, err_ready,
        input  in_ready, out_valid, out_funct3, out_rs1, out_rs2, out_passthrough,
               err_valid, err_funct3, err_passthrough, illegal_count
    );
endinterface

// File: rtl/request_dispatcher.sv
// Routes each request by funct3 into a one-entry slot per target (illegal ones to the error slot), 1-cycle latency.
// in_ready drops only when the slot the request decodes to is full and not draining this cycle.
module request_dispatcher #(
    parameter int          NUM_TARGETS  = 2,
    parameter int          DATA_WIDTH   = 32,
    parameter int          PT_WIDTH     = 8,
    parameter int          CNT_WIDTH    = 16,
    // funct3 0->0 (SEND), 1->1 (RECV), 2->1 (AVAIL); 3..7 are masked illegal
    parameter logic [23:0] TARGET_MAP   = 24'h00_0048,
    parameter logic [7:0]  ILLEGAL_MASK = 8'hF8
) (
    input  logic                clk,
    input  logic                rst,
    request_dispatcher_if.slave bus
);
    localparam logic [3:0] NT = 4'(NUM_TARGETS);

    logic [2:0]             map_entry [8];
    logic [2:0]             dest;
    logic                   illegal;
    logic                   tgt_free;
    logic                   err_free;
    logic                   in_rdy;
    logic                   accept;
    logic [NUM_TARGETS-1:0] slot_free;

    logic [NUM_TARGETS-1:0] vld_q;
    logic [2:0]             f3_q  [NUM_TARGETS];
    logic [DATA_WIDTH-1:0]  rs1_q [NUM_TARGETS];
    logic [DATA_WIDTH-1:0]  rs2_q [NUM_TARGETS];
    logic [PT_WIDTH-1:0]    pt_q  [NUM_TARGETS];
    logic                   err_vld_q;
    logic [2:0]             err_f3_q;
    logic [PT_WIDTH-1:0]    err_pt_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    for (genvar i = 0; i < 8; i++) begin : g_map
        assign map_entry[i] = TARGET_MAP[3*i +: 3];
    end

    assign dest      = map_entry[bus.in_funct3];
    assign illegal   = ILLEGAL_MASK[bus.in_funct3] | ({1'b0, dest} >= NT);
    assign slot_free = ~vld_q | bus.out_ready;
    assign err_free  = ~err_vld_q | bus.err_ready;

    always_comb begin
        tgt_free = 1'b0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (dest == 3'(t)) tgt_free = slot_free[t];
        end
    end

    // Never a function of in_valid, so the RR stage may wait on in_ready.
    assign in_rdy       = illegal ? err_free : tgt_free;
    assign bus.in_ready = in_rdy;
    assign accept       = bus.in_valid & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            err_vld_q <= 1'b0;
            err_f3_q  <= '0;
            err_pt_q  <= '0;
            cnt_q     <= '0;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                f3_q[t]  <= '0;
                rs1_q[t] <= '0;
                rs2_q[t] <= '0;
                pt_q[t]  <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (accept && !illegal && dest == 3'(t)) begin
                    vld_q[t] <= 1'b1;
                    f3_q[t]  <= bus.in_funct3;
                    rs1_q[t] <= bus.in_rs1;
                    rs2_q[t] <= bus.in_rs2;
                    pt_q[t]  <= bus.in_passthrough;
                end else if (bus.out_ready[t]) begin
                    vld_q[t] <= 1'b0;
                end
            end
            if (accept && illegal) begin
                err_vld_q <= 1'b1;
                err_f3_q  <= bus.in_funct3;
                err_pt_q  <= bus.in_passthrough;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else if (bus.err_ready) begin
                err_vld_q <= 1'b0;
            end
        end
    end

    for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_out
        assign bus.out_funct3[3*t +: 3]                      = f3_q[t];
        assign bus.out_rs1[DATA_WIDTH*t +: DATA_WIDTH]       = rs1_q[t];
        assign bus.out_rs2[DATA_WIDTH*t +: DATA_WIDTH]       = rs2_q[t];
        assign bus.out_passthrough[PT_WIDTH*t +: PT_WIDTH]   = pt_q[t];
    end

    assign bus.out_valid       = vld_q;
    assign bus.err_valid       = err_vld_q;
    assign bus.err_funct3      = err_f3_q;
    assign bus.err_passthrough = err_pt_q;
    assign bus.illegal_count   = cnt_q;
endmodule

// File: tb/tb_request_dispatcher.sv
// Bench for request_dispatcher: default config (table + random vs reference model)
// and a 3-target, 2-bit-counter config (hand sequences for saturation, routing, reset).
module tb_request_dispatcher;
    localparam logic [23:0] MAP_A  = 24'h00_0048;
    localparam logic [7:0]  MASK_A = 8'hF8;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    request_dispatcher_if #(.NUM_TARGETS(2), .DATA_WIDTH(32), .PT_WIDTH(8), .CNT_WIDTH(16)) bus_a();
    request_dispatcher_if #(.NUM_TARGETS(3), .DATA_WIDTH(32), .PT_WIDTH(8), .CNT_WIDTH(2))  bus_b();

    request_dispatcher #(
        .NUM_TARGETS(2), .DATA_WIDTH(32), .PT_WIDTH(8), .CNT_WIDTH(16),
        .TARGET_MAP(MAP_A), .ILLEGAL_MASK(MASK_A)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    request_dispatcher #(
        .NUM_TARGETS(3), .DATA_WIDTH(32), .PT_WIDTH(8), .CNT_WIDTH(2),
        .TARGET_MAP(24'h00_0088), .ILLEGAL_MASK(8'hF8)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of dut_a: what each slot should hold after every edge.
    logic [1:0]  m_vld;
    logic [2:0]  m_f3  [2];
    logic [31:0] m_rs1 [2];
    logic [31:0] m_rs2 [2];
    logic [7:0]  m_pt  [2];
    logic        m_ev;
    logic [2:0]  m_ef3;
    logic [7:0]  m_ept;
    int          m_cnt;

    task automatic model_reset();
        m_vld = 2'b00; m_ev = 1'b0; m_ef3 = 3'd0; m_ept = 8'd0; m_cnt = 0;
        for (int t = 0; t < 2; t++) begin
            m_f3[t] = 3'd0; m_rs1[t] = 32'd0; m_rs2[t] = 32'd0; m_pt[t] = 8'd0;
        end
    endtask

    function automatic int m_dest(input logic [2:0] f);
        return int'((MAP_A >> (3 * int'(f))) & 24'h7);
    endfunction

    task automatic cycle_a(input logic v, input logic [2:0] f, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [7:0] pt, input logic [1:0] ordy,
                           input logic erdy, input logic do_rst, output logic ir_seen);
        int   d;
        logic ill;
        logic mir;
        bus_a.in_valid = v; bus_a.in_funct3 = f; bus_a.in_rs1 = r1; bus_a.in_rs2 = r2;
        bus_a.in_passthrough = pt; bus_a.out_ready = ordy; bus_a.err_ready = erdy;
        rst_a = do_rst;
        #1;
        d   = m_dest(f);
        ill = MASK_A[f] || (d >= 2);
        mir = ill ? (!m_ev || erdy) : (!m_vld[d] || ordy[d]);
        ir_seen = bus_a.in_ready;
        chk("a_in_ready", 64'(bus_a.in_ready), 64'(mir));
        tick();
        if (do_rst) begin
            model_reset();
        end else begin
            for (int t = 0; t < 2; t++) if (m_vld[t] && ordy[t]) m_vld[t] = 1'b0;
            if (m_ev && erdy) m_ev = 1'b0;
            if (v && mir) begin
                if (ill) begin
                    m_ev = 1'b1; m_ef3 = f; m_ept = pt;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_vld[d] = 1'b1; m_f3[d] = f; m_rs1[d] = r1; m_rs2[d] = r2; m_pt[d] = pt;
                end
            end
        end
        chk("a_out_valid", 64'(bus_a.out_valid), 64'(m_vld));
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("a_funct3_%0d", t), 64'(bus_a.out_funct3[3*t +: 3]), 64'(m_f3[t]));
            chk($sformatf("a_rs1_%0d", t), 64'(bus_a.out_rs1[32*t +: 32]), 64'(m_rs1[t]));
            chk($sformatf("a_rs2_%0d", t), 64'(bus_a.out_rs2[32*t +: 32]), 64'(m_rs2[t]));
            chk($sformatf("a_pt_%0d", t), 64'(bus_a.out_passthrough[8*t +: 8]), 64'(m_pt[t]));
        end
        chk("a_err_valid", 64'(bus_a.err_valid), 64'(m_ev));
        chk("a_err_funct3", 64'(bus_a.err_funct3), 64'(m_ef3));
        chk("a_err_pt", 64'(bus_a.err_passthrough), 64'(m_ept));
        chk("a_count", 64'(bus_a.illegal_count), 64'(m_cnt));
    endtask

    task automatic drive_b(input logic v, input logic [2:0] f, input logic [7:0] pt,
                           input logic [2:0] ordy, input logic erdy);
        bus_b.in_valid = v; bus_b.in_funct3 = f; bus_b.in_passthrough = pt;
        bus_b.in_rs1 = {24'h0, pt}; bus_b.in_rs2 = ~{24'h0, pt};
        bus_b.out_ready = ordy; bus_b.err_ready = erdy;
    endtask

    typedef struct packed {
        logic        v;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [7:0]  pt;
        logic [1:0]  ordy;
        logic        erdy;
        logic        exp_ir;
        logic [1:0]  exp_ov;
        logic        exp_ev;
        logic [15:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] f3, input logic [31:0] rs1,
                                input logic [7:0] pt, input logic [1:0] ordy, input logic erdy,
                                input logic eir, input logic [1:0] eov, input logic eev,
                                input logic [15:0] ecnt);
        vec_t r;
        r.v = v; r.f3 = f3; r.rs1 = rs1; r.pt = pt; r.ordy = ordy; r.erdy = erdy;
        r.exp_ir = eir; r.exp_ov = eov; r.exp_ev = eev; r.exp_cnt = ecnt;
        return r;
    endfunction

    vec_t vecs [20];
    logic ir;

    initial begin
        // Idle, then 4 streamed SEND requests, RECV stall, then illegal traffic.
        vecs[0]  = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 0);
        vecs[3]  = mk(1, 0, 32'h1234_5678, 8'h5A, 2'b11, 1, 1, 2'b01, 0, 0);
        vecs[4]  = mk(1, 0, 32'h1234_5679, 8'h5B, 2'b11, 1, 1, 2'b01, 0, 0);
        vecs[5]  = mk(1, 0, 32'h1234_567A, 8'h5C, 2'b11, 1, 1, 2'b01, 0, 0);
        vecs[6]  = mk(1, 0, 32'h1234_567B, 8'h5D, 2'b11, 1, 1, 2'b01, 0, 0);
        vecs[7]  = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 0);
        vecs[8]  = mk(1, 1, 32'hAAAA_0001, 8'h61, 2'b00, 1, 1, 2'b10, 0, 0);
        vecs[9]  = mk(1, 2, 32'hAAAA_0002, 8'h62, 2'b00, 1, 0, 2'b10, 0, 0);
        vecs[10] = mk(1, 0, 32'hAAAA_0003, 8'h63, 2'b00, 1, 1, 2'b11, 0, 0);
        vecs[11] = mk(1, 2, 32'hAAAA_0002, 8'h62, 2'b10, 1, 1, 2'b11, 0, 0);
        vecs[12] = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 0);
        vecs[13] = mk(1, 5, 32'h0,        8'hA3, 2'b11, 0, 1, 2'b00, 1, 1);
        vecs[14] = mk(1, 6, 32'h0,        8'hA4, 2'b11, 0, 0, 2'b00, 1, 1);
        vecs[15] = mk(1, 6, 32'h0,        8'hA4, 2'b11, 1, 1, 2'b00, 1, 2);
        vecs[16] = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 2);
        vecs[17] = mk(1, 3, 32'h0,        8'hB3, 2'b11, 1, 1, 2'b00, 1, 3);
        vecs[18] = mk(1, 7, 32'h0,        8'hB7, 2'b11, 1, 1, 2'b00, 1, 4);
        vecs[19] = mk(0, 0, 32'h0,        8'h00, 2'b11, 1, 1, 2'b00, 0, 4);

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_funct3 = 3'd0; bus_a.in_rs1 = 32'd0; bus_a.in_rs2 = 32'd0;
        bus_a.in_passthrough = 8'd0; bus_a.out_ready = 2'b11; bus_a.err_ready = 1'b1;
        drive_b(1'b0, 3'd0, 8'd0, 3'b111, 1'b1);
        tick();
        tick();
        chk("a_reset_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("a_reset_err_valid", 64'(bus_a.err_valid), 64'd0);
        chk("a_reset_count", 64'(bus_a.illegal_count), 64'd0);
        model_reset();
        rst_a = 1'b0; rst_b = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cycle_a(vecs[i].v, vecs[i].f3, vecs[i].rs1, 32'hFF, vecs[i].pt, vecs[i].ordy,
                    vecs[i].erdy, 1'b0, ir);
            chk($sformatf("vec%0d_in_ready", i), 64'(ir), 64'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_out_valid", i), 64'(bus_a.out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_err_valid", i), 64'(bus_a.err_valid), 64'(vecs[i].exp_ev));
            chk($sformatf("vec%0d_count", i), 64'(bus_a.illegal_count), 64'(vecs[i].exp_cnt));
        end

        for (int i = 0; i < 400; i++) begin
            cycle_a($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    8'($urandom), 2'($urandom), $urandom_range(0, 3) != 0, i == 200, ir);
        end

        // Narrow counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive_b(1'b1, 3'd5, 8'(k), 3'b111, 1'b1);
            tick();
            chk($sformatf("b_count_%0d", k), 64'(bus_b.illegal_count), 64'((k + 1 > 3) ? 3 : k + 1));
            chk($sformatf("b_err_pt_%0d", k), 64'(bus_b.err_passthrough), 64'(k));
        end

        drive_b(1'b1, 3'd2, 8'hC2, 3'b000, 1'b1);
        #1 chk("b_in_ready_f2", 64'(bus_b.in_ready), 64'd1);
        tick();
        chk("b_out_valid_f2", 64'(bus_b.out_valid), 64'b100);
        chk("b_pt_slot2", 64'(bus_b.out_passthrough[23:16]), 64'hC2);
        chk("b_funct3_slot2", 64'(bus_b.out_funct3[8:6]), 64'd2);
        chk("b_rs1_slot2", 64'(bus_b.out_rs1[95:64]), 64'h0000_00C2);
        chk("b_err_drained", 64'(bus_b.err_valid), 64'd0);

        drive_b(1'b1, 3'd0, 8'hC0, 3'b000, 1'b0);
        tick();
        chk("b_out_valid_101", 64'(bus_b.out_valid), 64'b101);
        drive_b(1'b1, 3'd1, 8'hC1, 3'b000, 1'b0);
        tick();
        chk("b_out_valid_111", 64'(bus_b.out_valid), 64'b111);
        drive_b(1'b1, 3'd4, 8'hC4, 3'b000, 1'b0);
        tick();
        chk("b_err_full", 64'(bus_b.err_valid), 64'd1);
        chk("b_count_sat", 64'(bus_b.illegal_count), 64'd3);
        drive_b(1'b1, 3'd2, 8'hDD, 3'b000, 1'b0);
        #1 chk("b_in_ready_stalled", 64'(bus_b.in_ready), 64'd0);

        rst_b = 1'b1;
        drive_b(1'b0, 3'd0, 8'h00, 3'b000, 1'b0);
        tick();
        chk("b_rst_out_valid", 64'(bus_b.out_valid), 64'd0);
        chk("b_rst_err_valid", 64'(bus_b.err_valid), 64'd0);
        chk("b_rst_count", 64'(bus_b.illegal_count), 64'd0);
        chk("b_rst_pt", 64'(bus_b.out_passthrough), 64'd0);
        chk("b_rst_err_pt", 64'(bus_b.err_passthrough), 64'd0);
        rst_b = 1'b0;

        drive_b(1'b1, 3'd2, 8'hE2, 3'b111, 1'b1);
        tick();
        chk("b_after_rst_route", 64'(bus_b.out_valid), 64'b100);
        drive_b(1'b0, 3'd0, 8'h00, 3'b111, 1'b1);
        tick();
        chk("b_after_rst_drain", 64'(bus_b.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
